// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU codes,
// FSM states, datapath mux selects and trap causes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, TRAP
  } state_e;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;
  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;
  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller (master) and the
// shared-ALU datapath / unified memory (slave).
interface multicycle_control_if #(
  parameter int ALUOP_W = 4
);
  logic [31:0]        instr;
  logic               mem_ready;
  logic               alu_zero;
  logic               mem_req;
  logic               mem_we;
  logic               mem_iord;
  logic               ir_write;
  logic               pc_write;
  logic               pc_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               reg_write;
  logic               mem_to_reg;
  logic               instr_done;
  logic               fault;
  logic [1:0]         fault_cause;

  modport master (
    input  instr, mem_ready, alu_zero,
    output mem_req, mem_we, mem_iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           instr_done, fault, fault_cause
  );

  modport slave (
    output instr, mem_ready, alu_zero,
    input  mem_req, mem_we, mem_iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           instr_done, fault, fault_cause
  );
endinterface

// File: rtl/multicycle_control_alu_control.sv
// Combinational funct3/funct7 decode into an ALU code plus an illegal flag,
// for register (R) and immediate (I) arithmetic classes.
module alu_control
  import riscv_ctrl_pkg::*;
(
  input  logic       is_rtype_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  // For I-type, funct7 is immediate bits and only matters for the shifts.
  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (funct3_i)
      3'b000:  alu_op_o = (is_rtype_i && funct7_i[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_o = ALU_SLL;
      3'b010:  alu_op_o = ALU_SLT;
      3'b011:  alu_op_o = ALU_SLTU;
      3'b100:  alu_op_o = ALU_XOR;
      3'b101:  alu_op_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_o = ALU_OR;
      default: alu_op_o = ALU_AND;
    endcase
    if (is_rtype_i) begin
      illegal_o = !((funct7_i == 7'h00) ||
                    ((funct7_i == 7'h20) && ((funct3_i == 3'b000) || (funct3_i == 3'b101))));
    end else if (funct3_i == 3'b001) begin
      illegal_o = (funct7_i != 7'h00);
    end else if (funct3_i == 3'b101) begin
      illegal_o = (funct7_i != 7'h00) && (funct7_i != 7'h20);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset controller: FSM, memory wait counter with timeout
// trap, and Moore/Mealy decode of datapath control signals.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  cause_e           cause_q, cause_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] aluCode;
  logic       aluIllegal;
  logic       illegalInstr;
  logic       isReq;
  logic       readyEff;
  logic       unusedInstrBits;

  assign opcode          = bus.instr[6:0];
  assign funct3          = bus.instr[14:12];
  assign funct7          = bus.instr[31:25];
  assign unusedInstrBits = ^{bus.instr[24:15], bus.instr[11:7]};
  assign isReq           = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  // Memory completions seen while reset is held must not fire write strobes.
  assign readyEff        = bus.mem_ready && !rst;

  alu_control u_alu_control (
    .is_rtype_i (opcode == OP_R),
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .alu_op_o   (aluCode),
    .illegal_o  (aluIllegal)
  );

  always_comb begin
    case (opcode)
      OP_R, OP_I:         illegalInstr = aluIllegal;
      OP_LOAD, OP_STORE:  illegalInstr = (funct3 != 3'b010);
      OP_BRANCH:          illegalInstr = (funct3[2:1] != 2'b00);
      default:            illegalInstr = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = '0;
    cause_d   = cause_q;
    if (isReq && !bus.mem_ready) begin
      if (waitCnt_q == CNT_W'(TIMEOUT)) begin
        state_d = TRAP;
        cause_d = CAUSE_TIMEOUT;
      end else begin
        waitCnt_d = waitCnt_q + CNT_W'(1);
      end
    end else begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          if (illegalInstr) begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            case (opcode)
              OP_R:              state_d = EXEC_R;
              OP_I:              state_d = EXEC_I;
              OP_LOAD, OP_STORE: state_d = MEM_ADDR;
              default:           state_d = BRANCH;
            endcase
          end
        end
        EXEC_R, EXEC_I: state_d = WB_ALU;
        MEM_ADDR:       state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD:         state_d = WB_MEM;
        TRAP:           state_d = TRAP;
        default:        state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      waitCnt_q <= '0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_iord    = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = PC_SRC_ALU;
    bus.alu_src_a   = SRC_A_PC;
    bus.alu_src_b   = SRC_B_RS2;
    bus.alu_op      = ALUOP_W'(ALU_ADD);
    bus.reg_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.instr_done  = 1'b0;
    bus.fault       = (state_q == TRAP);
    bus.fault_cause = cause_q;
    case (state_q)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = SRC_B_FOUR;
        bus.ir_write  = readyEff;
        bus.pc_write  = readyEff;
      end
      DECODE: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_IMM;
      end
      EXEC_R: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_op    = ALUOP_W'(aluCode);
      end
      EXEC_I: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_op    = ALUOP_W'(aluCode);
      end
      MEM_ADDR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
      end
      MEM_RD: begin
        bus.mem_req  = 1'b1;
        bus.mem_iord = 1'b1;
      end
      MEM_WR: begin
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_iord   = 1'b1;
        bus.instr_done = readyEff;
      end
      WB_ALU: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a  = SRC_A_RS1;
        bus.alu_op     = ALUOP_W'(ALU_SUB);
        bus.pc_src     = PC_SRC_ALUOUT;
        bus.pc_write   = ((funct3 == 3'b000) && bus.alu_zero) ||
                         ((funct3 == 3'b001) && !bus.alu_zero);
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scenario-driven bench for multicycle_control: each cycle's stimulus and the
// expected control word are queued together, then replayed and compared.
module tb_multicycle_control;

  typedef struct packed {
    logic       memReq, memWe, memIord, irWrite, pcWrite, pcSrc;
    logic [1:0] srcA, srcB;
    logic [3:0] aluOp;
    logic       regWrite, memToReg, instrDone, fault;
    logic [1:0] cause;
  } ctl_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        rdy;
    logic        zero;
  } stim_t;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SLL   = 32'h002091B3;
  localparam logic [31:0] I_SRA   = 32'h4020D1B3;
  localparam logic [31:0] I_SLTU  = 32'h0020B1B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_XORI  = 32'hFFF0C093;
  localparam logic [31:0] I_LW    = 32'h0080A283;
  localparam logic [31:0] I_SW    = 32'h0050A423;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_BNE   = 32'h00209063;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_SLLIX = 32'h40009093;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;
  stim_t stimQ[$];
  ctl_t  expQ[$];

  multicycle_control_if #(.ALUOP_W(4)) bus ();

  multicycle_control #(.ALUOP_W(4), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t mk(input logic req, we, iord, irw, pcw, pcs,
                              input logic [1:0] a, b, input logic [3:0] op,
                              input logic rw, m2r, done, flt, input logic [1:0] cause);
    ctl_t c;
    c = '{req, we, iord, irw, pcw, pcs, a, b, op, rw, m2r, done, flt, cause};
    return c;
  endfunction

  function automatic ctl_t eFetch(input logic rdy);
    return mk(1, 0, 0, rdy, rdy, 0, 2'd0, 2'd1, 4'd0, 0, 0, 0, 0, 2'd0);
  endfunction
  function automatic ctl_t eDecode();
    return mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 4'd0, 0, 0, 0, 0, 2'd0);
  endfunction
  function automatic ctl_t eExec(input logic [1:0] b, input logic [3:0] op);
    return mk(0, 0, 0, 0, 0, 0, 2'd2, b, op, 0, 0, 0, 0, 2'd0);
  endfunction
  function automatic ctl_t eWbAlu();
    return mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 1, 0, 1, 0, 2'd0);
  endfunction
  function automatic ctl_t eMemRd();
    return mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0);
  endfunction
  function automatic ctl_t eWbMem();
    return mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 1, 1, 1, 0, 2'd0);
  endfunction
  function automatic ctl_t eMemWr(input logic rdy);
    return mk(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, rdy, 0, 2'd0);
  endfunction
  function automatic ctl_t eBranch(input logic pcw);
    return mk(0, 0, 0, 0, pcw, 1, 2'd2, 2'd0, 4'd1, 0, 0, 1, 0, 2'd0);
  endfunction
  function automatic ctl_t eTrap(input logic [1:0] cause);
    return mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, 0, 1, cause);
  endfunction

  function automatic ctl_t actual();
    return '{bus.mem_req, bus.mem_we, bus.mem_iord, bus.ir_write, bus.pc_write,
             bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
             bus.mem_to_reg, bus.instr_done, bus.fault, bus.fault_cause};
  endfunction

  task automatic applyStimulus(input string name, input logic [31:0] ins,
                               input logic rdy, input logic zero, input ctl_t exp);
    stimQ.push_back('{name, ins, rdy, zero});
    expQ.push_back(exp);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Four-cycle fetch/decode/exec/writeback with zero-wait memory.
  task automatic pushAlu(input string name, input logic [31:0] ins,
                         input logic [1:0] b, input logic [3:0] op);
    applyStimulus({name, "_fetch"}, ins, 1, 0, eFetch(1));
    applyStimulus({name, "_decode"}, ins, 1, 0, eDecode());
    applyStimulus({name, "_exec"}, ins, 1, 0, eExec(b, op));
    applyStimulus({name, "_wb"}, ins, 1, 0, eWbAlu());
  endtask

  task automatic test_reset();
    ctl_t a;
    rst = 1'b1;
    bus.instr = I_ADD;
    bus.mem_ready = 1'b1;
    bus.alu_zero = 1'b0;
    #2;
    a = actual();
    testsRun++;
    if (a !== eFetch(0)) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", a, eFetch(0));
    end
    @(posedge clk); #1;
    a = actual();
    testsRun++;
    if (a !== eFetch(0)) begin
      testsFailed++;
      $display("[TB] FAIL reset_held_over_edge: got %h expected %h", a, eFetch(0));
    end
  endtask

  task automatic test_alu_ops();
    stim_t s; ctl_t e, a;
    resetDut();
    pushAlu("add", I_ADD, 2'd0, 4'd0);
    pushAlu("sub", I_SUB, 2'd0, 4'd1);
    pushAlu("sll", I_SLL, 2'd0, 4'd5);
    pushAlu("sra", I_SRA, 2'd0, 4'd7);
    pushAlu("sltu", I_SLTU, 2'd0, 4'd9);
    pushAlu("srai", I_SRAI, 2'd2, 4'd7);
    pushAlu("xori", I_XORI, 2'd2, 4'd4);
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      bus.instr = s.ins; bus.mem_ready = s.rdy; bus.alu_zero = s.zero;
      @(negedge clk);
      e = expQ.pop_front(); a = actual(); testsRun++;
      if (a !== e) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h expected %h", s.name, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  // Three wait cycles in MEM_RD put WB_MEM at cycle index 7 (the eighth cycle).
  task automatic test_load_wait();
    stim_t s; ctl_t e, a;
    resetDut();
    applyStimulus("lw_fetch", I_LW, 1, 0, eFetch(1));
    applyStimulus("lw_decode", I_LW, 1, 0, eDecode());
    applyStimulus("lw_addr", I_LW, 1, 0, eExec(2'd2, 4'd0));
    for (int i = 0; i < 3; i++) applyStimulus("lw_rd_wait", I_LW, 0, 0, eMemRd());
    applyStimulus("lw_rd_ready", I_LW, 1, 0, eMemRd());
    applyStimulus("lw_wb_mem", I_LW, 1, 0, eWbMem());
    applyStimulus("lw_next_fetch", I_SW, 1, 0, eFetch(1));
    applyStimulus("sw_decode", I_SW, 1, 0, eDecode());
    applyStimulus("sw_addr", I_SW, 1, 0, eExec(2'd2, 4'd0));
    applyStimulus("sw_write", I_SW, 1, 0, eMemWr(1));
    applyStimulus("sw_next_fetch", I_ADD, 1, 0, eFetch(1));
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      bus.instr = s.ins; bus.mem_ready = s.rdy; bus.alu_zero = s.zero;
      @(negedge clk);
      e = expQ.pop_front(); a = actual(); testsRun++;
      if (a !== e) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h expected %h", s.name, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s; ctl_t e, a;
    resetDut();
    applyStimulus("beq_fetch", I_BEQ, 1, 0, eFetch(1));
    applyStimulus("beq_decode", I_BEQ, 1, 0, eDecode());
    applyStimulus("beq_taken", I_BEQ, 1, 1, eBranch(1));
    applyStimulus("bne_fetch", I_BNE, 1, 1, eFetch(1));
    applyStimulus("bne_decode", I_BNE, 1, 1, eDecode());
    applyStimulus("bne_not_taken", I_BNE, 1, 1, eBranch(0));
    applyStimulus("bne2_fetch", I_BNE, 1, 0, eFetch(1));
    applyStimulus("bne2_decode", I_BNE, 1, 0, eDecode());
    applyStimulus("bne_taken", I_BNE, 1, 0, eBranch(1));
    applyStimulus("beq2_fetch", I_BEQ, 1, 0, eFetch(1));
    applyStimulus("beq2_decode", I_BEQ, 1, 0, eDecode());
    applyStimulus("beq_not_taken", I_BEQ, 1, 0, eBranch(0));
    applyStimulus("branch_next_fetch", I_ADD, 1, 0, eFetch(1));
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      bus.instr = s.ins; bus.mem_ready = s.rdy; bus.alu_zero = s.zero;
      @(negedge clk);
      e = expQ.pop_front(); a = actual(); testsRun++;
      if (a !== e) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h expected %h", s.name, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  // Each illegal encoding traps right after DECODE; mem_ready=1 must not move it.
  task automatic test_illegal();
    stim_t s; ctl_t e, a;
    logic [31:0] bad [3];
    int holdCycles [3];
    bad = '{I_BAD, I_MUL, I_SLLIX};
    holdCycles = '{20, 5, 5};
    for (int k = 0; k < 3; k++) begin
      resetDut();
      applyStimulus("illegal_fetch", bad[k], 1, 0, eFetch(1));
      applyStimulus("illegal_decode", bad[k], 1, 0, eDecode());
      for (int i = 0; i < holdCycles[k]; i++)
        applyStimulus($sformatf("illegal%0d_trap_hold", k), bad[k], 1, 1, eTrap(2'd1));
      while (stimQ.size() > 0) begin
        s = stimQ.pop_front();
        bus.instr = s.ins; bus.mem_ready = s.rdy; bus.alu_zero = s.zero;
        @(negedge clk);
        e = expQ.pop_front(); a = actual(); testsRun++;
        if (a !== e) begin
          testsFailed++;
          $display("[TB] FAIL %s: got %h expected %h", s.name, a, e);
        end
        @(posedge clk); #1;
      end
    end
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    a = actual();
    testsRun++;
    if (a !== eFetch(0)) begin
      testsFailed++;
      $display("[TB] FAIL reset_from_trap: got %h expected %h", a, eFetch(0));
    end
  endtask

  task automatic test_timeout();
    stim_t s; ctl_t e, a;
    for (int k = 0; k < 2; k++) begin
      resetDut();
      for (int i = 0; i < 15; i++) applyStimulus("fetch_wait", I_ADD, 0, 0, eFetch(0));
      if (k == 0) begin
        applyStimulus("fetch_wait_last", I_ADD, 0, 0, eFetch(0));
        applyStimulus("timeout_trap", I_ADD, 1, 0, eTrap(2'd2));
        applyStimulus("timeout_trap_held", I_ADD, 1, 0, eTrap(2'd2));
      end else begin
        applyStimulus("ready_at_limit", I_ADD, 1, 0, eFetch(1));
        applyStimulus("ready_at_limit_decode", I_ADD, 1, 0, eDecode());
        applyStimulus("ready_at_limit_exec", I_ADD, 1, 0, eExec(2'd0, 4'd0));
      end
      while (stimQ.size() > 0) begin
        s = stimQ.pop_front();
        bus.instr = s.ins; bus.mem_ready = s.rdy; bus.alu_zero = s.zero;
        @(negedge clk);
        e = expQ.pop_front(); a = actual(); testsRun++;
        if (a !== e) begin
          testsFailed++;
          $display("[TB] FAIL %s: got %h expected %h", s.name, a, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_midwrite();
    stim_t s; ctl_t e, a;
    resetDut();
    applyStimulus("sw_fetch", I_SW, 1, 0, eFetch(1));
    applyStimulus("sw_decode", I_SW, 1, 0, eDecode());
    applyStimulus("sw_addr", I_SW, 1, 0, eExec(2'd2, 4'd0));
    applyStimulus("sw_wait0", I_SW, 0, 0, eMemWr(0));
    applyStimulus("sw_wait1", I_SW, 0, 0, eMemWr(0));
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      bus.instr = s.ins; bus.mem_ready = s.rdy; bus.alu_zero = s.zero;
      @(negedge clk);
      e = expQ.pop_front(); a = actual(); testsRun++;
      if (a !== e) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h expected %h", s.name, a, e);
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    #1;
    a = actual();
    testsRun++;
    if (a !== eMemWr(0)) begin
      testsFailed++;
      $display("[TB] FAIL sw_wait_before_reset: got %h expected %h", a, eMemWr(0));
    end
    rst = 1'b1;
    #1;
    a = actual();
    testsRun++;
    if (a !== eFetch(0)) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_write: got %h expected %h", a, eFetch(0));
    end
    bus.mem_ready = 1'b1;
    #1;
    a = actual();
    testsRun++;
    if (a !== eFetch(0)) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_strobes: got %h expected %h", a, eFetch(0));
    end
    rst = 1'b0;
    pushAlu("after_reset_add", I_ADD, 2'd0, 4'd0);
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      bus.instr = s.ins; bus.mem_ready = s.rdy; bus.alu_zero = s.zero;
      @(negedge clk);
      e = expQ.pop_front(); a = actual(); testsRun++;
      if (a !== e) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h expected %h", s.name, a, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
